neureka_colpres_accum: RTL and testbench
========================================

# neureka_colpres_accum

Receiving end of the column partial-result stream emitted by a binconv column. Sign-extends each incoming scaled column result and accumulates it into one of `N_ACC` spatial accumulators over a programmed number of iterations. Once all iterations are done, it drains the accumulators in order on an output stream to the downstream accumulator/normquant stage.

## Interface

**Parameters**
- `PRES_WIDTH`, default `NEUREKA_QA_IN+$clog2(NEUREKA_COLUMN_SIZE)+NEUREKA_QA_16BIT+8`: width of the incoming column result (signed two's complement).
- `ACC_WIDTH`, default 32: accumulator and output width; must be ≥ `PRES_WIDTH`.
- `N_ACC`, default 9: number of spatial accumulators.
- `ITER_W`, default 8: width of the iteration-count field.

**Ports**
- `clk_gated`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `enable_i`, in, 1: local enable; low freezes all state.
- `clear_i`, in, 1: synchronous clear to IDLE.
- `col_pres_i`, `hwpe_stream_intf_stream.sink`, `PRES_WIDTH`: column partial results.
- `acc_o`, `hwpe_stream_intf_stream.source`, `ACC_WIDTH`: drained accumulators; `strb='1`.
- `start_i`, in, 1: start pulse.
- `n_pos_m1_i`, in, `$clog2(N_ACC)`: positions per iteration minus 1; values ≥ `N_ACC` are saturated to `N_ACC-1`.
- `n_iter_m1_i`, in, `ITER_W`: iterations minus 1.
- `busy_o`, out, 1: state ≠ IDLE.
- `done_o`, out, 1: one-cycle pulse after the last drain handshake.

## Operation

**States: IDLE, ACCUM, DRAIN.**
- **IDLE**
  - `col_pres_i.ready=0`, `acc_o.valid=0`.
  - On `start_i & enable_i`: latch `n_pos_m1` and `n_iter_m1`, zero all accumulators, zero `pos` and `iter`, then go to ACCUM.
- **ACCUM**
  - `col_pres_i.ready = enable_i`.
  - On each handshake:
    - `acc[pos] <= acc[pos] + sext(data)`, modulo `2^ACC_WIDTH`; no saturation, no overflow flag.
    - If `pos==n_pos_m1`: `pos <= 0`, `iter <= iter+1`.
    - Otherwise: `pos <= pos+1`.
  - A handshake at `pos==n_pos_m1` and `iter==n_iter_m1` performs the final add, resets `pos` to 0, and moves to DRAIN.
- **DRAIN**
  - `acc_o.valid = enable_i`; `acc_o.data = acc[pos]` (registered value, mux only).
  - On each `acc_o` handshake: `pos++`.
  - The handshake at `pos==n_pos_m1` moves to IDLE and asserts `done_o` for one cycle.
  - `col_pres_i.ready=0`.
- **Ignored inputs**
  - `start_i` is ignored outside IDLE.
  - Input valids are ignored in IDLE and DRAIN.
- **`clear_i`**
  - Has priority over everything, including a simultaneous `start_i` or handshake.
  - Next cycle: IDLE, accumulators and counters zero, `done_o=0`.
  - Takes effect regardless of `enable_i`.
- **`enable_i=0`**
  - No state, counter or accumulator change.
  - `ready` and `valid` are both forced low, so no handshake can complete.
- **Reset values:** state IDLE, all accumulators 0, counters 0, `busy_o=0`, `done_o=0`, `acc_o.valid=0`, `acc_o.data=0`, `col_pres_i.ready=0`.

## Timing

- Start latency: ACCUM is entered on the cycle after `start_i`; `ready` is high from that cycle.
- Input throughput: 1 accumulation per cycle, with no bubbles across position or iteration wrap.
- Accumulate-to-output latency:
  - The first `acc_o.valid` is seen in the cycle after the final input handshake.
  - That value already includes the final add.
- Drain throughput: 1 word per cycle while `acc_o.ready=1`.
- Output stability: while `valid & ~ready`, data and valid hold stable.
- `done_o` timing: asserted in the cycle after the last drain handshake; `busy_o` is 0 in that same cycle.
- Back-to-back jobs: a `start_i` in the cycle `done_o` is high is accepted.
- Total cycles, IDLE→IDLE, with no stalls: `1 + (n_pos)(n_iter) + n_pos` handshake cycles plus the start cycle.

## Test plan

- **Single position, single iteration:** `n_pos_m1=0`, `n_iter_m1=0`, input `+5`.
  - `acc_o` = 5 in the cycle after the input handshake.
  - `done_o` pulses on the following cycle.
- **Multi-position, multi-iteration with negatives:** `n_pos_m1=2`, `n_iter_m1=1`, inputs `1,2,3,10,-20,30`.
  - Drained values are `11, -18, 33`, sign-extended to 32 bits.
- **Output backpressure:** hold `acc_o.ready=0` for 4 cycles during DRAIN.
  - Data and valid stay constant; the drain order is unchanged; `done_o` comes only after the last accepted word.
- **Clear mid-accumulation:** `clear_i` after 3 of 6 handshakes.
  - `busy_o=0` next cycle.
  - A new start with input `7` drains `7`, with no residue from the cleared job.
- **Enable freeze:** drop `enable_i` for 5 cycles mid-ACCUM while valid stays high.
  - `ready=0`, counters hold, and the final sums match the unstalled run.
- **Wrap-around:** `ACC_WIDTH=32` with positive inputs whose sum exceeds `2^31-1`.
  - Output equals the sum modulo `2^32`, with no saturation.

Source files
------------

// File: rtl/neureka_colpres_accum_if.sv
// Valid/ready stream bundle used for the column result input and the accumulator drain output.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/neureka_colpres_accum.sv
// Accumulates sign-extended column partial results into N_ACC spatial accumulators over
// a programmed number of iterations, then drains them in position order.
module neureka_colpres_accum #(
  // QA_IN(8) + clog2(COLUMN_SIZE=9) + QA_16BIT(8) + 8
  parameter int unsigned PRES_WIDTH = 28,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned N_ACC      = 9,
  parameter int unsigned ITER_W     = 8,
  localparam int unsigned POS_W     = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
  input  logic                   clk_gated,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   clear_i,
  hwpe_stream_intf_stream.sink   col_pres_i,
  hwpe_stream_intf_stream.source acc_o,
  input  logic                   start_i,
  input  logic [POS_W-1:0]       n_pos_m1_i,
  input  logic [ITER_W-1:0]      n_iter_m1_i,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ACC_WIDTH-1:0]  r_acc [N_ACC];
  logic [POS_W-1:0]      r_pos;
  logic [ITER_W-1:0]     r_iter;
  logic [POS_W-1:0]      r_n_pos_m1;
  logic [ITER_W-1:0]     r_n_iter_m1;
  logic                  r_done;

  logic                  w_in_rdy;
  logic                  w_out_vld;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  w_last_pos;
  logic                  w_last_iter;
  logic [POS_W-1:0]      w_n_pos_m1_sat;
  logic signed [PRES_WIDTH-1:0] w_pres;
  logic [ACC_WIDTH-1:0]  w_sext;
  logic [ACC_WIDTH-1:0]  w_acc_sel;

  // Position counts beyond the accumulator bank collapse onto the last accumulator.
  assign w_n_pos_m1_sat = (32'(n_pos_m1_i) >= N_ACC) ? POS_W'(N_ACC - 1) : n_pos_m1_i;

  assign w_pres      = col_pres_i.data[PRES_WIDTH-1:0];
  assign w_sext      = ACC_WIDTH'(w_pres);
  assign w_last_pos  = (r_pos == r_n_pos_m1);
  assign w_last_iter = (r_iter == r_n_iter_m1);
  assign w_in_hs     = w_in_rdy & col_pres_i.valid;
  assign w_out_hs    = w_out_vld & acc_o.ready;
  assign w_acc_sel   = (32'(r_pos) < N_ACC) ? r_acc[r_pos] : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    w_out_vld   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i && enable_i) w_state_nxt = ACCUM;
      end
      ACCUM: begin
        w_in_rdy = enable_i;
        if (w_in_rdy && col_pres_i.valid && w_last_pos && w_last_iter) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_out_vld = enable_i;
        if (w_out_vld && acc_o.ready && w_last_pos) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clear_i) w_state_nxt = IDLE;
  end

  // Transitions already require enable_i via start or a handshake, so no extra gating here.
  always_ff @(posedge clk_gated or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_gated or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_ACC; i++) r_acc[i] <= '0;
      r_pos       <= '0;
      r_iter      <= '0;
      r_n_pos_m1  <= '0;
      r_n_iter_m1 <= '0;
      r_done      <= 1'b0;
    end else if (clear_i) begin
      for (int i = 0; i < N_ACC; i++) r_acc[i] <= '0;
      r_pos       <= '0;
      r_iter      <= '0;
      r_n_pos_m1  <= '0;
      r_n_iter_m1 <= '0;
      r_done      <= 1'b0;
    end else if (enable_i) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            for (int i = 0; i < N_ACC; i++) r_acc[i] <= '0;
            r_pos       <= '0;
            r_iter      <= '0;
            r_n_pos_m1  <= w_n_pos_m1_sat;
            r_n_iter_m1 <= n_iter_m1_i;
          end
        end
        ACCUM: begin
          if (w_in_hs) begin
            r_acc[r_pos] <= r_acc[r_pos] + w_sext;
            if (w_last_pos) begin
              r_pos  <= '0;
              r_iter <= r_iter + 1'b1;
            end else begin
              r_pos  <= r_pos + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_out_hs) begin
            if (w_last_pos) begin
              r_pos  <= '0;
              r_done <= 1'b1;
            end else begin
              r_pos  <= r_pos + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign col_pres_i.ready = w_in_rdy;
  assign acc_o.valid      = w_out_vld;
  assign acc_o.data       = w_acc_sel;
  assign acc_o.strb       = '1;
  assign busy_o           = (r_state != IDLE);
  assign done_o           = r_done;

endmodule

// File: tb/tb_neureka_colpres_accum.sv
// Scenario bench for neureka_colpres_accum: a reference model queues expected drain words,
// a monitor pops and compares them on every output handshake.
module tb_neureka_colpres_accum;
  localparam int PW   = 28;
  localparam int AW   = 32;
  localparam int NA   = 9;
  localparam int IW   = 8;
  localparam int POSW = 4;

  logic            clk_gated   = 1'b0;
  logic            rst_ni      = 1'b0;
  logic            enable_i    = 1'b1;
  logic            clear_i     = 1'b0;
  logic            start_i     = 1'b0;
  logic [POSW-1:0] n_pos_m1_i  = '0;
  logic [IW-1:0]   n_iter_m1_i = '0;
  logic            busy_o;
  logic            done_o;

  hwpe_stream_intf_stream #(.DATA_WIDTH(PW)) col_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(AW)) acc_if ();

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_exp;

  always #5 clk_gated = ~clk_gated;

  neureka_colpres_accum #(
    .PRES_WIDTH(PW), .ACC_WIDTH(AW), .N_ACC(NA), .ITER_W(IW)
  ) dut (
    .clk_gated   (clk_gated),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .clear_i     (clear_i),
    .col_pres_i  (col_if),
    .acc_o       (acc_if),
    .start_i     (start_i),
    .n_pos_m1_i  (n_pos_m1_i),
    .n_iter_m1_i (n_iter_m1_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // Inputs change on the falling edge; sample just before the next rising edge.
  always @(negedge clk_gated) begin
    #4;
    if (rst_ni && acc_if.valid && acc_if.ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL drain_unexpected: got %0h, no word expected", acc_if.data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (acc_if.data !== mon_exp) begin
          n_fail++;
          $display("FAIL drain_data: got %0h expected %0h", acc_if.data, mon_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_job(input int vals[$], input int npos);
    logic [AW-1:0] s [NA];
    for (int i = 0; i < NA; i++) s[i] = '0;
    foreach (vals[i]) s[i % npos] = s[i % npos] + AW'(vals[i]);
    for (int p = 0; p < npos; p++) exp_q.push_back(s[p]);
  endtask

  task automatic start_job(input int npos_m1, input int niter_m1);
    @(negedge clk_gated);
    n_pos_m1_i  = POSW'(npos_m1);
    n_iter_m1_i = IW'(niter_m1);
    start_i     = 1'b1;
    @(negedge clk_gated);
    start_i     = 1'b0;
  endtask

  task automatic push_in(input int v, inout int stalls);
    col_if.valid = 1'b1;
    col_if.data  = PW'(v);
    #1;
    for (int i = 0; i < 20 && !col_if.ready; i++) begin
      stalls++;
      @(negedge clk_gated);
      #1;
    end
    if (!col_if.ready) stalls += 1000;
    @(negedge clk_gated);
  endtask

  task automatic push_all(input int vals[$], inout int stalls);
    foreach (vals[i]) push_in(vals[i], stalls);
    col_if.valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done_o !== 1'b1 && cycles < 200) begin
      @(negedge clk_gated);
      cycles++;
    end
  endtask

  task automatic test_reset;
    acc_if.ready = 1'b1;
    col_if.valid = 1'b0;
    col_if.data  = '0;
    col_if.strb  = '1;
    rst_ni       = 1'b0;
    repeat (2) @(negedge clk_gated);
    n_checks += 5;
    if (busy_o !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    if (done_o !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_o); end
    if (acc_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", acc_if.valid); end
    if (acc_if.data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", acc_if.data); end
    if (col_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", col_if.ready); end
    rst_ni = 1'b1;
    @(negedge clk_gated);
    n_checks++;
    if (col_if.ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 0", col_if.ready); end
  endtask

  task automatic test_single;
    int v[$];
    int stalls = 0;
    int c;
    v = '{5};
    model_job(v, 1);
    start_job(0, 0);
    n_checks += 2;
    if (col_if.ready !== 1'b1) begin n_fail++; $display("FAIL single_start_ready: got %b expected 1", col_if.ready); end
    if (busy_o !== 1'b1)       begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy_o); end
    push_all(v, stalls);
    n_checks++;
    if (acc_if.valid !== 1'b1) begin n_fail++; $display("FAIL single_first_valid: got %b expected 1", acc_if.valid); end
    wait_done(c);
    n_checks += 2;
    if (c != 1)          begin n_fail++; $display("FAIL single_done_latency: got %0d expected 1", c); end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done: got %b expected 0", busy_o); end
    @(negedge clk_gated);
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 0", done_o); end
  endtask

  task automatic test_multi;
    int v[$];
    int stalls = 0;
    int c;
    v = '{1, 2, 3, 10, -20, 30};
    model_job(v, 3);
    start_job(2, 1);
    push_all(v, stalls);
    n_checks += 2;
    if (stalls != 0)           begin n_fail++; $display("FAIL multi_in_bubbles: got %0d expected 0", stalls); end
    if (acc_if.valid !== 1'b1) begin n_fail++; $display("FAIL multi_first_valid: got %b expected 1", acc_if.valid); end
    wait_done(c);
    n_checks += 2;
    if (c != 3)              begin n_fail++; $display("FAIL multi_drain_cycles: got %0d expected 3", c); end
    if (exp_q.size() != 0)   begin n_fail++; $display("FAIL multi_words_left: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure;
    int v[$];
    int stalls = 0;
    int c;
    v = '{100, -1, 7};
    model_job(v, 3);
    start_job(2, 0);
    push_all(v, stalls);
    acc_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks += 3;
      if (acc_if.valid !== 1'b1)  begin n_fail++; $display("FAIL bp_valid_hold: got %b expected 1", acc_if.valid); end
      if (acc_if.data !== 32'd100) begin n_fail++; $display("FAIL bp_data_hold: got %0h expected 64", acc_if.data); end
      if (done_o !== 1'b0)        begin n_fail++; $display("FAIL bp_early_done: got %b expected 0", done_o); end
      @(negedge clk_gated);
    end
    acc_if.ready = 1'b1;
    wait_done(c);
    n_checks++;
    if (c != 3) begin n_fail++; $display("FAIL bp_drain_cycles: got %0d expected 3", c); end
  endtask

  task automatic test_clear;
    int v[$];
    int stalls = 0;
    int c;
    start_job(2, 1);
    push_in(1, stalls);
    push_in(2, stalls);
    push_in(3, stalls);
    col_if.data = PW'(99);
    clear_i     = 1'b1;
    @(negedge clk_gated);
    clear_i      = 1'b0;
    col_if.valid = 1'b0;
    n_checks += 3;
    if (busy_o !== 1'b0)       begin n_fail++; $display("FAIL clear_busy: got %b expected 0", busy_o); end
    if (acc_if.valid !== 1'b0) begin n_fail++; $display("FAIL clear_out_valid: got %b expected 0", acc_if.valid); end
    if (col_if.ready !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready: got %b expected 0", col_if.ready); end
    v = '{7};
    model_job(v, 1);
    start_job(0, 0);
    push_all(v, stalls);
    wait_done(c);
    n_checks++;
    if (c != 1) begin n_fail++; $display("FAIL clear_restart_done: got %0d expected 1", c); end
  endtask

  task automatic test_freeze;
    int v[$];
    int stalls = 0;
    int c;
    v = '{5, 6, 7, -8, 9, 100};
    model_job(v, 3);
    start_job(2, 1);
    for (int i = 0; i < 3; i++) push_in(v[i], stalls);
    enable_i     = 1'b0;
    col_if.valid = 1'b1;
    col_if.data  = PW'(-8);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks += 3;
      if (col_if.ready !== 1'b0) begin n_fail++; $display("FAIL freeze_in_ready: got %b expected 0", col_if.ready); end
      if (acc_if.valid !== 1'b0) begin n_fail++; $display("FAIL freeze_out_valid: got %b expected 0", acc_if.valid); end
      if (busy_o !== 1'b1)       begin n_fail++; $display("FAIL freeze_busy: got %b expected 1", busy_o); end
      @(negedge clk_gated);
    end
    enable_i = 1'b1;
    for (int i = 3; i < 6; i++) push_in(v[i], stalls);
    col_if.valid = 1'b0;
    wait_done(c);
    n_checks += 2;
    if (stalls != 0) begin n_fail++; $display("FAIL freeze_stalls: got %0d expected 0", stalls); end
    if (c != 3)      begin n_fail++; $display("FAIL freeze_drain_cycles: got %0d expected 3", c); end
  endtask

  task automatic test_saturate;
    int v[$];
    int stalls = 0;
    int c;
    for (int i = 1; i <= 9; i++) v.push_back(i * 11);
    model_job(v, 9);
    start_job(15, 0);
    push_all(v, stalls);
    wait_done(c);
    n_checks++;
    if (c != 9) begin n_fail++; $display("FAIL sat_drain_cycles: got %0d expected 9", c); end
  endtask

  task automatic test_wrap;
    int v[$];
    int stalls = 0;
    int c;
    for (int i = 0; i < 40; i++) begin
      v.push_back(134217727);
      v.push_back(120000000);
    end
    model_job(v, 2);
    start_job(1, 39);
    push_all(v, stalls);
    wait_done(c);
    n_checks++;
    if (c != 2) begin n_fail++; $display("FAIL wrap_drain_cycles: got %0d expected 2", c); end
  endtask

  task automatic test_back_to_back;
    int v[$];
    int stalls = 0;
    int c;
    v = '{3};
    model_job(v, 1);
    start_job(0, 0);
    push_all(v, stalls);
    wait_done(c);
    v = '{4};
    model_job(v, 1);
    n_pos_m1_i  = '0;
    n_iter_m1_i = '0;
    start_i     = 1'b1;
    @(negedge clk_gated);
    start_i = 1'b0;
    n_checks += 2;
    if (busy_o !== 1'b1)       begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy_o); end
    if (col_if.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b expected 1", col_if.ready); end
    push_all(v, stalls);
    wait_done(c);
    n_checks++;
    if (c != 1) begin n_fail++; $display("FAIL b2b_done_latency: got %0d expected 1", c); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_clear();
    test_freeze();
    test_saturate();
    test_wrap();
    test_back_to_back();
    repeat (2) @(negedge clk_gated);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL words_undrained: got %0d expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
